inst_mem_loader: RTL

//  Writer side of the byte-addressed, big-endian instruction memory: packs an incoming byte stream

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/byte_packer.sv | 59 +++++
 rtl/inst_mem_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg (package)
// Purpose  : Shared definitions for the instruction-memory loader: loader
//            state encoding, bytes-per-word and the default memory size,
//            plus the big-endian byte shift helper used by the packer.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_MEM_BYTES = 256;

  // Big-endian packing: earlier bytes migrate toward [31:24].
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  byte_in);
    return {word[23:0], byte_in};
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : 32-bit shift register plus 2-bit byte counter. Packs four
//            accepted bytes into a big-endian word.
// Ports    : clk, rst_n        - clock, async active-low reset
//            clr_i             - synchronous clear of the byte counter
//            byte_valid_i      - a byte is accepted this cycle
//            byte_i[7:0]       - byte data
//            word_o[31:0]      - word including the byte accepted this cycle
//            word_ready_o      - combinational pulse: this byte completes a word
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q,   cnt_d;

  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_ready_o = 1'b0;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      shift_d      = shift_in_byte(shift_q, byte_i);
      cnt_d        = cnt_q + 2'd1;   // wraps to 0 after the 4th byte
      word_ready_o = (cnt_q == LAST_BYTE);
    end
  end

  // Exposing the next value lets the loader register the word on the same
  // edge that accepts its final byte.
  assign word_o = shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Writer side of the big-endian instruction memory. Packs a byte
//            stream into 32-bit words, issues one-cycle word writes and
//            stalls the CPU while a program is loading.
// Config   : LOADER_CHECKSUM_EN - when defined, a trailing XOR checksum byte
//            is checked after the last word (err on mismatch).
// Ports    : clk, rst_n               - clock, async active-low reset
//            start_i, len_words_i     - begin a load of len_words_i words
//            in_valid_i, in_data_i    - byte stream in
//            in_ready_o               - byte accepted when valid & ready
//            wr_en_o, wr_addr_o,
//            wr_data_o                - memory word-write port
//            cpu_stall_o              - hold fetch/PC while loading
//            busy_o, done_o, err_o    - status
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader
  import pipe_pkg::*;
#(
  parameter int          MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_words_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             cpu_stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / BYTES_PER_WORD);

  loader_state_e    state_q;
  logic [CNT_W-1:0] words_total_q;
  logic [CNT_W-1:0] word_idx_q;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             cpu_stall_q;

  logic             w_accept;
  logic             w_load_byte;
  logic             w_start_ok;
  logic [CNT_W-1:0] w_len_clamped;
  logic             w_last_word;
  logic [31:0]      w_word;
  logic             w_word_ready;

  assign w_accept      = in_valid_i & in_ready_q;
  assign w_load_byte   = w_accept & (state_q == ST_LOAD);
  assign w_start_ok    = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign w_len_clamped = (len_words_i > MAX_WORDS) ? MAX_WORDS : len_words_i;
  assign w_last_word   = ((word_idx_q + CNT_W'(1)) == words_total_q);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (w_start_ok),
    .byte_valid_i (w_load_byte),
    .byte_i       (in_data_i),
    .word_o       (w_word),
    .word_ready_o (w_word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      words_total_q <= '0;
      word_idx_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cpu_stall_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      wr_en_q     <= 1'b0;
      // Stall tracks busy unless a branch below also has a write in flight.
      cpu_stall_q <= busy_q;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            words_total_q <= w_len_clamped;
            word_idx_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= '0;
            err_q         <= 1'b0;
`endif
            if (w_len_clamped == '0) begin
              // Empty load: no bytes taken, no stall, done next cycle.
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b0;
              cpu_stall_q <= 1'b0;
            end else begin
              state_q     <= ST_LOAD;
              done_q      <= 1'b0;
              busy_q      <= 1'b1;
              in_ready_q  <= 1'b1;
              cpu_stall_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_load_byte) begin
            csum_q <= csum_q ^ in_data_i;
          end
`endif
          if (w_word_ready) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= BASE_ADDR + 32'({word_idx_q, 2'b00});
            wr_data_q  <= w_word;
            word_idx_q <= word_idx_q + CNT_W'(1);
            if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_q     <= ST_CHECK;
`else
              // Leave LOAD on the same edge that raises the final wr_en;
              // stall covers that write cycle only.
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b0;
              done_q      <= 1'b1;
              cpu_stall_q <= 1'b1;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            err_q       <= (in_data_i != csum_q);
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            cpu_stall_q <= 1'b0;
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign cpu_stall_o = cpu_stall_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule
`default_nettype wire
